// File: rtl/pix_pkg.sv
// Shared pixel types for the RGB444 scramble/unscramble path.
// Channel selects index the scrambled pixel as R=0, G=1, B=2.
package pix_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef logic [1:0] ch_sel_t;

  localparam ch_sel_t SEL_R    = 2'd0;
  localparam ch_sel_t SEL_G    = 2'd1;
  localparam ch_sel_t SEL_B    = 2'd2;
  localparam ch_sel_t SEL_ZERO = 2'd3;

  localparam logic [5:0] CFG_IDENTITY = 6'b00_01_10;

  function automatic logic [3:0] ch_get(
    rgb444_t p,
    ch_sel_t s
  );
    logic [3:0] v;
    case (s)
      SEL_R:   v = p.r;
      SEL_G:   v = p.g;
      SEL_B:   v = p.b;
      default: v = 4'h0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/color_unscramble_stream_if.sv
// Valid/ready pixel stream with start/end-of-frame markers.
// Master drives the beat, slave drives ready.
interface color_unscramble_stream_if;
  import pix_pkg::*;

  logic    valid;
  logic    ready;
  rgb444_t data;
  logic    sof;
  logic    eof;

  modport master (
    output valid, data, sof, eof,
    input  ready
  );

  modport slave (
    input  valid, data, sof, eof,
    output ready
  );

endinterface

// File: rtl/unscramble_decode.sv
// Inverts a forward scramble code into per-channel source selects.
// Lowest scrambled channel wins when a select is duplicated.
module unscramble_decode
  import pix_pkg::*;
(
  input  logic [5:0]    code_i,
  output ch_sel_t [2:0] sel_o,
  output logic [2:0]    vld_o,
  output logic          err_o
);

  ch_sel_t [2:0] fwd;

  assign fwd[0] = code_i[5:4];
  assign fwd[1] = code_i[3:2];
  assign fwd[2] = code_i[1:0];

  // Descending scan: the last write is the lowest match.
  always_comb begin
    sel_o = {3{SEL_ZERO}};
    vld_o = '0;
    for (int j = 0; j < 3; j++) begin
      for (int c = 2; c >= 0; c--) begin
        if (fwd[c] == ch_sel_t'(j[1:0])) begin
          sel_o[j] = ch_sel_t'(c[1:0]);
          vld_o[j] = 1'b1;
        end
      end
    end
  end

  // Three selects cover three targets only as a permutation.
  assign err_o = ~&vld_o;

endmodule

// File: rtl/color_unscramble_stream.sv
// Two-stage streaming inverse of the RGB444 channel scramble.
// Code is latched on sof beats and carried with each beat.
module color_unscramble_stream
  import pix_pkg::*;
#(
  parameter int unsigned PIX_W     = 12,
  parameter logic [5:0]  CFG_RESET = CFG_IDENTITY
) (
  input  logic clk,
  input  logic rst,
  input  logic [5:0] sw,
  color_unscramble_stream_if.slave  s,
  color_unscramble_stream_if.master m,
  output logic map_err
);

  logic             adv1, adv2, take;
  logic [5:0]       code;
  logic [PIX_W-1:0] s_pix;
  ch_sel_t [2:0]    dsel;
  logic [2:0]       dvld;
  logic             derr;

  logic          v1_q, v2_q;
  logic [5:0]    cfg_q;
  logic          err_q;
  rgb444_t       d1_q;
  ch_sel_t [2:0] sel1_q;
  logic [2:0]    ok1_q;
  logic          sof1_q, eof1_q;
  rgb444_t       d2_q, d2_d;
  logic          sof2_q, eof2_q;

  assign adv2    = !v2_q | m.ready;
  assign adv1    = !v1_q | adv2;
  assign take    = s.valid & adv1;
  assign s.ready = adv1;
  assign s_pix   = s.data;
  assign code    = s.sof ? sw : cfg_q;

  unscramble_decode u_dec (
    .code_i (code),
    .sel_o  (dsel),
    .vld_o  (dvld),
    .err_o  (derr)
  );

  always_comb begin
    d2_d   = '0;
    d2_d.r = ok1_q[0] ? ch_get(d1_q, sel1_q[0]) : 4'h0;
    d2_d.g = ok1_q[1] ? ch_get(d1_q, sel1_q[1]) : 4'h0;
    d2_d.b = ok1_q[2] ? ch_get(d1_q, sel1_q[2]) : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      cfg_q  <= CFG_RESET;
      err_q  <= 1'b0;
      d1_q   <= '0;
      sel1_q <= '0;
      ok1_q  <= '0;
      sof1_q <= 1'b0;
      eof1_q <= 1'b0;
      d2_q   <= '0;
      sof2_q <= 1'b0;
      eof2_q <= 1'b0;
    end else begin
      if (take && s.sof) begin
        cfg_q <= sw;
        err_q <= derr;
      end
      if (adv1) begin
        v1_q <= s.valid;
      end
      if (take) begin
        d1_q   <= rgb444_t'(s_pix);
        sel1_q <= dsel;
        ok1_q  <= dvld;
        sof1_q <= s.sof;
        eof1_q <= s.eof;
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          d2_q   <= d2_d;
          sof2_q <= sof1_q;
          eof2_q <= eof1_q;
        end
      end
    end
  end

  assign m.valid = v2_q;
  assign m.data  = d2_q;
  assign m.sof   = sof2_q;
  assign m.eof   = eof2_q;
  assign map_err = err_q;

endmodule
